threshold_reset_gen: RTL and testbench

Synchronous threshold monitor and reset-pulse generator sitting directly downstream of the counter/adder datapath. It watches the summed counter value and, once the value has stayed above a programmable threshold for a qualification window, drives a fixed-width reset request back to the counters. A holdoff period follows the pulse so the counters can settle before the value is sampled again. Trip events are counted for observability.

---
 rtl/threshold_reset_gen.sv | 99 +++++++++
 tb/tb_threshold_reset_gen.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/threshold_reset_gen.sv
// Threshold monitor: once `in` has exceeded THRESH for QUAL consecutive enabled
// cycles, emits a PULSE_LEN-cycle reset request followed by a HOLDOFF-cycle ignore window.
module threshold_reset_gen #(
  parameter int unsigned SIZE      = 8,
  parameter int unsigned THRESH    = 10,
  parameter int unsigned QUAL      = 1,
  parameter int unsigned PULSE_LEN = 2,
  parameter int unsigned HOLDOFF   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SIZE-1:0] in,
  input  logic            en,
  input  logic            clear,
  output logic            rst_out,
  output logic            busy,
  output logic [7:0]      trip_count
);

  localparam int unsigned QW   = $clog2(QUAL + 1);
  localparam int unsigned PMAX = (PULSE_LEN > HOLDOFF) ? PULSE_LEN : HOLDOFF;
  localparam int unsigned PW   = $clog2(PMAX + 1);

  typedef enum logic [1:0] {IDLE, PULSE, HOLD} state_t;

  state_t        state_reg, state_next;
  logic [QW-1:0] q_reg, q_next;
  logic [PW-1:0] p_reg, p_next;
  logic [7:0]    count_reg, count_next;
  logic          trip;
  logic          cond;

  // Widened compare so a THRESH at or above the value range simply never trips.
  assign cond = en && (32'(in) > THRESH);

  always_comb begin
    state_next = state_reg;
    q_next     = '0;
    p_next     = '0;
    trip       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (cond) begin
          if (32'(q_reg) == QUAL - 1) begin
            state_next = PULSE;
            trip       = 1'b1;
          end else begin
            q_next = q_reg + 1'b1;
          end
        end
      end
      PULSE: begin
        if (32'(p_reg) == PULSE_LEN - 1) begin
          state_next = (HOLDOFF == 0) ? IDLE : HOLD;
        end else begin
          p_next = p_reg + 1'b1;
        end
      end
      HOLD: begin
        if (32'(p_reg) == HOLDOFF - 1) begin
          state_next = IDLE;
        end else begin
          p_next = p_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    if (clear) begin
      count_next = '0;
    end else if (trip && count_reg != 8'hFF) begin
      count_next = count_reg + 8'd1;
    end else begin
      count_next = count_reg;
    end
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      q_reg     <= '0;
      p_reg     <= '0;
      count_reg <= '0;
      rst_out   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_reg <= state_next;
      q_reg     <= q_next;
      p_reg     <= p_next;
      count_reg <= count_next;
      rst_out   <= (state_next == PULSE);
      busy      <= (state_next != IDLE);
    end
  end

  assign trip_count = count_reg;

endmodule

// File: tb/tb_threshold_reset_gen.sv
// Bench for threshold_reset_gen: five parameterisations share one stimulus stream
// and are checked every cycle against a remaining-busy-cycles model.
module tb_threshold_reset_gen;

  localparam int N = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic clear = 1'b0;
  logic [7:0] din = 8'd0;
  logic [N-1:0] ro, bz;
  logic [7:0] tc [N];

  int unsigned th [N] = '{10, 10, 10, 254, 255};
  int unsigned qa [N] = '{1, 3, 1, 1, 1};
  int unsigned pl [N] = '{2, 2, 3, 2, 2};
  int unsigned ho [N] = '{4, 4, 0, 4, 4};

  int run [N];
  int rem [N];
  int cnt [N];
  int ncmp = 0;
  int nbad = 0;

  always #5 clk = ~clk;

  threshold_reset_gen #(.SIZE(8), .THRESH(10), .QUAL(1), .PULSE_LEN(2), .HOLDOFF(4)) u_def (
    .clk(clk), .rst(rst), .in(din), .en(en), .clear(clear),
    .rst_out(ro[0]), .busy(bz[0]), .trip_count(tc[0]));
  threshold_reset_gen #(.SIZE(8), .THRESH(10), .QUAL(3), .PULSE_LEN(2), .HOLDOFF(4)) u_q3 (
    .clk(clk), .rst(rst), .in(din), .en(en), .clear(clear),
    .rst_out(ro[1]), .busy(bz[1]), .trip_count(tc[1]));
  threshold_reset_gen #(.SIZE(8), .THRESH(10), .QUAL(1), .PULSE_LEN(3), .HOLDOFF(0)) u_h0 (
    .clk(clk), .rst(rst), .in(din), .en(en), .clear(clear),
    .rst_out(ro[2]), .busy(bz[2]), .trip_count(tc[2]));
  threshold_reset_gen #(.SIZE(8), .THRESH(254), .QUAL(1), .PULSE_LEN(2), .HOLDOFF(4)) u_b254 (
    .clk(clk), .rst(rst), .in(din), .en(en), .clear(clear),
    .rst_out(ro[3]), .busy(bz[3]), .trip_count(tc[3]));
  threshold_reset_gen #(.SIZE(8), .THRESH(255), .QUAL(1), .PULSE_LEN(2), .HOLDOFF(4)) u_b255 (
    .clk(clk), .rst(rst), .in(din), .en(en), .clear(clear),
    .rst_out(ro[4]), .busy(bz[4]), .trip_count(tc[4]));

  // Model: after a trip the block is busy for PULSE_LEN+HOLDOFF cycles, the
  // first PULSE_LEN of which drive rst_out; run counts consecutive qualifying samples.
  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < N; i++) begin
      bit t;
      t = 1'b0;
      if (rst) begin
        run[i] = 0;
        rem[i] = 0;
        cnt[i] = 0;
      end else begin
        if (rem[i] > 0) begin
          rem[i] = rem[i] - 1;
          run[i] = 0;
        end else if (en && (int'(din) > int'(th[i]))) begin
          run[i] = run[i] + 1;
          if (run[i] == int'(qa[i])) begin
            t = 1'b1;
            run[i] = 0;
            rem[i] = int'(pl[i] + ho[i]);
          end
        end else begin
          run[i] = 0;
        end
        if (clear) cnt[i] = 0;
        else if (t && cnt[i] < 255) cnt[i] = cnt[i] + 1;
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      bit ero, ebz;
      ero = (rem[i] > int'(ho[i]));
      ebz = (rem[i] > 0);
      ncmp += 3;
      if (ro[i] !== ero) begin
        nbad++;
        $display("FAIL t=%0t inst%0d rst_out got %b want %b", $time, i, ro[i], ero);
      end
      if (bz[i] !== ebz) begin
        nbad++;
        $display("FAIL t=%0t inst%0d busy got %b want %b", $time, i, bz[i], ebz);
      end
      if (tc[i] !== 8'(cnt[i])) begin
        nbad++;
        $display("FAIL t=%0t inst%0d trip_count got %0d want %0d", $time, i, tc[i], cnt[i]);
      end
    end
  end

  task automatic pin(input string nm, input int act, input int exp);
    ncmp++;
    if (act != exp) begin
      nbad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end else begin
      $display("check %s = %0d ok", nm, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    step();
    step();
    rst = 1'b0;
    pin("reset rst_out", int'(ro), 0);
    pin("reset busy", int'(bz), 0);
    pin("reset trip_count", int'(tc[0]) + int'(tc[1]) + int'(tc[4]), 0);

    // Basic trip with defaults
    en = 1'b1;
    din = 8'd10;
    for (int j = 0; j < 5; j++) step();
    pin("basic no trip at 10", int'(ro[0]), 0);
    din = 8'd11;
    step();
    pin("basic rst_out rise", int'(ro[0]), 1);
    pin("basic trip_count", int'(tc[0]), 1);
    din = 8'd10;
    step();
    pin("basic pulse cycle2", int'(ro[0]), 1);
    step();
    pin("basic pulse fall", int'(ro[0]), 0);
    pin("basic holdoff busy", int'(bz[0]), 1);
    for (int j = 0; j < 3; j++) step();
    pin("basic holdoff last", int'(bz[0]), 1);
    step();
    pin("basic idle again", int'(bz[0]), 0);

    // Qualification with QUAL=3
    do_reset();
    din = 8'd11; step();
    din = 8'd11; step();
    din = 8'd5;  step();
    din = 8'd11; step();
    din = 8'd11; step();
    pin("qual3 not yet", int'(ro[1]), 0);
    din = 8'd11; step();
    pin("qual3 trip", int'(ro[1]), 1);
    pin("qual3 count", int'(tc[1]), 1);
    din = 8'd0;

    // Enable gating and holdoff spacing
    do_reset();
    en = 1'b0;
    din = 8'd200;
    for (int j = 0; j < 10; j++) step();
    pin("en0 no trip", int'(tc[0]), 0);
    en = 1'b1;
    step();
    pin("en1 trip", int'(ro[0]), 1);
    en = 1'b0;
    step();
    pin("pulse ignores en", int'(ro[0]), 1);
    en = 1'b1;
    step();
    pin("pulse length 2", int'(ro[0]), 0);
    for (int j = 0; j < 4; j++) step();
    pin("holdoff no retrigger", int'(ro[0]), 0);
    step();
    pin("retrigger at +7", int'(ro[0]), 1);
    pin("retrigger count", int'(tc[0]), 2);

    // Asynchronous reset mid-pulse
    do_reset();
    din = 8'd11;
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    pin("async rst_out", int'(ro[0]), 0);
    pin("async busy", int'(bz[0]), 0);
    pin("async trip_count", int'(tc[0]), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    pin("post-reset trip", int'(ro[0]), 1);
    pin("post-reset count", int'(tc[0]), 1);

    // Saturation and clear on the HOLDOFF=0 instance
    do_reset();
    din = 8'd255;
    for (int j = 0; j < 1250; j++) step();
    pin("saturate 255", int'(tc[2]), 255);
    for (int b = 0; b < 20 && ro[2] !== 1'b0; b++) step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    pin("clear beats trip", int'(tc[2]), 0);
    pin("trip on clear edge", int'(ro[2]), 1);
    for (int j = 0; j < 4; j++) step();
    pin("count after clear", int'(tc[2]), 1);

    // Boundary thresholds
    do_reset();
    din = 8'd254;
    for (int j = 0; j < 10; j++) step();
    pin("th254 in254", int'(tc[3]), 0);
    din = 8'd255;
    step();
    pin("th254 in255 trip", int'(ro[3]), 1);
    for (int j = 0; j < 20; j++) step();
    pin("th255 never", int'(tc[4]), 0);

    // Randomised traffic
    do_reset();
    for (int j = 0; j < 2000; j++) begin
      case ($urandom_range(0, 3))
        0: din = 8'($urandom_range(0, 255));
        1: din = 8'($urandom_range(9, 12));
        2: din = 8'($urandom_range(252, 255));
        default: din = 8'd200;
      endcase
      en = ($urandom_range(0, 9) != 0);
      clear = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1;
        #2;
        rst = 1'b0;
      end
      step();
    end
    clear = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
